// File: rtl/mem_bus_arbiter_if.sv
// Bundle of every bus signal around the RAM-port arbiter.
//   master : requester / RAM side (drives requests, RAM read data and RAM ack)
//   slave  : arbiter side (drives acks, read data, stalls and the RAM command)
// IF port  : if_req_i, if_addr_i -> if_ack_o, if_data_o, stall_if_o
// MEM port : mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i
//            -> mem_ack_o, mem_data_o, stall_mem_o
// RAM port : ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
//            <- ram_data_i, ram_ack_i
// err_o    : accompanies an ack when that transaction was aborted by timeout
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_data_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [3:0]        mem_sel_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_data_o;

    logic              err_o;
    logic              stall_if_o;
    logic              stall_mem_o;

    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [3:0]        ram_sel_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;
    logic              ram_ack_i;

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output ram_data_i, ram_ack_i,
        input  if_ack_o, if_data_o, mem_ack_o, mem_data_o,
        input  err_o, stall_if_o, stall_mem_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  ram_data_i, ram_ack_i,
        output if_ack_o, if_data_o, mem_ack_o, mem_data_o,
        output err_o, stall_if_o, stall_mem_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external RAM port between instruction fetch (read-only) and the
// data path (read/write with byte selects). MEM has priority over IF, but after
// MAX_MEM_STREAK consecutive MEM grants with IF waiting, IF is forced through.
// One transaction at a time; a watchdog aborts a transaction that never sees
// ram_ack_i within TIMEOUT_CYCLES busy cycles (0 disables it).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; drops any in-flight transaction
//   bus  : mem_bus_arbiter_if.slave (requesters, RAM command/response, stalls)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate; latch the winner's command into the ram_* regs
// BUSY_IF  | IF transaction on the RAM port, waiting for ack / timeout
// BUSY_MEM | MEM transaction on the RAM port, waiting for ack / timeout
// DONE     | one-cycle ack pulse to the granted requester, no arbitration
module mem_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_arbiter_if.slave     bus
);
    localparam int STREAK_W = (MAX_MEM_STREAK < 2) ? 1 : $clog2(MAX_MEM_STREAK + 1);
    localparam int TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                ram_ce_q, ram_ce_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [3:0]          ram_sel_q, ram_sel_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;

    logic                grant_mem;
    logic                tmo_hit;
    logic                finish;

    // MEM wins unless IF is waiting and MEM has used up its streak allowance.
    assign grant_mem = bus.mem_req_i & ~(bus.if_req_i & (streak_q == STREAK_MAX));
    assign tmo_hit   = TMO_EN & (tmo_q == TMO_LAST);
    assign finish    = bus.ram_ack_i | tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            tmo_q      <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_sel_q  <= '0;
            ram_data_q <= '0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            err_q      <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_sel_q  <= ram_sel_d;
            ram_data_q <= ram_data_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
            err_q      <= err_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        ram_ce_d   = ram_ce_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_sel_d  = ram_sel_q;
        ram_data_d = ram_data_q;
        if_ack_d   = 1'b0;
        mem_ack_d  = 1'b0;
        err_d      = 1'b0;
        if_data_d  = '0;
        mem_data_d = '0;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (grant_mem) begin
                    state_d    = BUSY_MEM;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = bus.mem_we_i;
                    ram_addr_d = bus.mem_addr_i;
                    ram_sel_d  = bus.mem_sel_i;
                    ram_data_d = bus.mem_data_i;
                    // Streak only counts MEM grants that made IF wait.
                    if (!bus.if_req_i) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.if_req_i) begin
                    state_d    = BUSY_IF;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.if_addr_i;
                    ram_sel_d  = 4'b1111;
                    ram_data_d = '0;
                    streak_d   = '0;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                tmo_d = tmo_q + 1'b1;
                if (finish) begin
                    state_d    = DONE;
                    ram_ce_d   = 1'b0;
                    ram_we_d   = 1'b0;
                    ram_addr_d = '0;
                    ram_sel_d  = '0;
                    ram_data_d = '0;
                    // A real ack beats a coincident timeout.
                    err_d      = ~bus.ram_ack_i;
                    if (state_q == BUSY_IF) begin
                        if_ack_d  = 1'b1;
                        if_data_d = bus.ram_ack_i ? bus.ram_data_i : '0;
                    end else begin
                        mem_ack_d  = 1'b1;
                        mem_data_d = (bus.ram_ack_i && !ram_we_q) ? bus.ram_data_i : '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ram_ce_o    = ram_ce_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_sel_o   = ram_sel_q;
    assign bus.ram_data_o  = ram_data_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.mem_ack_o   = mem_ack_q;
    assign bus.err_o       = err_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.stall_if_o  = bus.if_req_i & ~if_ack_q;
    assign bus.stall_mem_o = bus.mem_req_i & ~mem_ack_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TMO    = 8;
    localparam int STREAK = 4;
    localparam logic [31:0] IF_ADDR = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .MAX_MEM_STREAK(STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          ack_delay;   // busy-cycle index of ram_ack_i, -1 = never
        logic [31:0] rdata;
        bit          exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dout;
        bit          exp_err;
        int          exp_ack_cyc; // cycles from ram_ce_o rise to requester ack
    } vec_t;

    vec_t vecs[6];

    logic [7:0] grant_bits;
    int         grant_cnt;
    int         stamps[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.mem_req_i  = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = '0;
        bus.mem_sel_i  = '0;
        bus.mem_data_i = '0;
        bus.ram_ack_i  = 1'b0;
        bus.ram_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ram_cmd"}, {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o}, 0);
        chk({tag, "_ram_wdata"}, bus.ram_data_o, 0);
        chk({tag, "_acks_err"}, {bus.if_ack_o, bus.mem_ack_o, bus.err_o}, 0);
        chk({tag, "_rdata"}, {bus.if_data_o, bus.mem_data_o}, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cnt;
        bit got;
        if (v.is_mem) begin
            bus.mem_req_i  = 1'b1;
            bus.mem_we_i   = v.we;
            bus.mem_addr_i = v.addr;
            bus.mem_sel_i  = v.sel;
            bus.mem_data_i = v.wdata;
        end else begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = v.addr;
        end
        #1;
        chk({tag, "_stall_req"}, v.is_mem ? bus.stall_mem_o : bus.stall_if_o, 1);
        step();
        chk({tag, "_ce_latency"}, bus.ram_ce_o, 1);
        chk({tag, "_ram_we"}, bus.ram_we_o, v.exp_we);
        chk({tag, "_ram_sel"}, bus.ram_sel_o, v.exp_sel);
        chk({tag, "_ram_addr"}, bus.ram_addr_o, v.addr);
        if (v.we) chk({tag, "_ram_wdata"}, bus.ram_data_o, v.wdata);
        chk({tag, "_stall_busy"}, v.is_mem ? bus.stall_mem_o : bus.stall_if_o, 1);
        // Requester inputs wander while busy; the RAM command must not follow.
        bus.mem_addr_i = ~v.addr;
        bus.if_addr_i  = ~v.addr;
        bus.mem_sel_i  = ~v.sel;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            if (cnt > 0 && bus.ram_ce_o)
                chk({tag, "_addr_held"}, bus.ram_addr_o, v.addr);
            bus.ram_ack_i  = (cnt == v.ack_delay);
            bus.ram_data_i = (cnt == v.ack_delay) ? v.rdata : $urandom;
            step();
            cnt++;
            got = v.is_mem ? bus.mem_ack_o : bus.if_ack_o;
        end
        bus.ram_ack_i = 1'b0;
        chk({tag, "_ack_seen"}, got, 1);
        chk({tag, "_ack_latency"}, cnt, v.exp_ack_cyc);
        chk({tag, "_dout"}, v.is_mem ? bus.mem_data_o : bus.if_data_o, v.exp_dout);
        chk({tag, "_err"}, bus.err_o, v.exp_err);
        chk({tag, "_other_ack"}, v.is_mem ? bus.if_ack_o : bus.mem_ack_o, 0);
        chk({tag, "_ce_done"}, bus.ram_ce_o, 0);
        chk({tag, "_stall_ack"}, v.is_mem ? bus.stall_mem_o : bus.stall_if_o, 0);
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        step();
        chk({tag, "_after"}, {bus.if_ack_o, bus.mem_ack_o, bus.err_o, bus.ram_ce_o}, 0);
    endtask

    // Records each new RAM grant (1 = MEM, 0 = IF) with RAM acking immediately.
    task automatic collect_grants(input bit mem_keep, input int n);
        int cyc;
        bit prev;
        grant_bits = '0;
        grant_cnt  = 0;
        stamps.delete();
        cyc  = 0;
        prev = 1'b0;
        while (grant_cnt < n && cyc < 200) begin
            if (bus.ram_ce_o && !prev) begin
                grant_bits = {grant_bits[6:0], (bus.ram_addr_o != IF_ADDR)};
                grant_cnt++;
                stamps.push_back(cyc);
            end
            prev = bus.ram_ce_o;
            if (bus.if_ack_o) bus.if_req_i = 1'b0;
            if (bus.mem_ack_o && !mem_keep) bus.mem_req_i = 1'b0;
            bus.ram_ack_i  = bus.ram_ce_o;
            bus.ram_data_i = '0;
            step();
            cyc++;
        end
        bus.ram_ack_i = 1'b0;
        chk("grants_collected", grant_cnt, n);
    endtask

    // Randomized traffic against a transaction-level reference model.
    task automatic random_run(input int n_cycles);
        int phase;       // 0 idle, 1 transaction on RAM, 2 ack cycle
        int busy_idx, ack_at, streak_m;
        bit if_pend, mem_pend, cur_mem, cur_we, acked, mem_wins;
        logic [31:0] if_a, mem_a, mem_d, cur_a, cur_d, rd_now;
        logic [3:0]  mem_s, cur_s;
        bit mem_w;
        bit e_if_ack, e_mem_ack, e_err;
        logic [31:0] e_if_data, e_mem_data;
        phase = 0; busy_idx = 0; ack_at = 0; streak_m = 0;
        if_pend = 0; mem_pend = 0; cur_mem = 0; cur_we = 0;
        if_a = '0; mem_a = '0; mem_d = '0; mem_s = '0; mem_w = 0;
        cur_a = '0; cur_d = '0; cur_s = '0;
        e_if_ack = 0; e_mem_ack = 0; e_err = 0; e_if_data = '0; e_mem_data = '0;
        for (int cyc = 0; cyc < n_cycles; cyc++) begin
            chk("rnd_if_ack", bus.if_ack_o, e_if_ack);
            chk("rnd_mem_ack", bus.mem_ack_o, e_mem_ack);
            chk("rnd_err", bus.err_o, e_err);
            chk("rnd_if_data", bus.if_data_o, e_if_data);
            chk("rnd_mem_data", bus.mem_data_o, e_mem_data);
            chk("rnd_ce", bus.ram_ce_o, (phase == 1));
            if (phase == 1) begin
                chk("rnd_ram_addr", bus.ram_addr_o, cur_a);
                chk("rnd_ram_we", bus.ram_we_o, cur_we);
                chk("rnd_ram_sel", bus.ram_sel_o, cur_s);
                if (cur_we) chk("rnd_ram_wdata", bus.ram_data_o, cur_d);
            end else begin
                chk("rnd_ram_idle", {bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o}, 0);
            end

            if (e_if_ack) if_pend = 0;
            else if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1;
                if_a = $urandom;
            end
            if (e_mem_ack) mem_pend = 0;
            else if (!mem_pend && $urandom_range(0, 2) == 0) begin
                mem_pend = 1;
                mem_a = $urandom;
                mem_d = $urandom;
                mem_w = $urandom_range(0, 1);
                mem_s = 4'($urandom_range(1, 15));
            end
            bus.if_req_i   = if_pend;
            bus.if_addr_i  = if_a;
            bus.mem_req_i  = mem_pend;
            bus.mem_we_i   = mem_w;
            bus.mem_addr_i = mem_a;
            bus.mem_sel_i  = mem_s;
            bus.mem_data_i = mem_d;
            bus.ram_ack_i  = (phase == 1) && (busy_idx == ack_at);
            rd_now = $urandom;
            bus.ram_data_i = rd_now;
            #1;
            chk("rnd_stall_if", bus.stall_if_o, if_pend);
            chk("rnd_stall_mem", bus.stall_mem_o, mem_pend);

            e_if_ack = 0; e_mem_ack = 0; e_err = 0; e_if_data = '0; e_mem_data = '0;
            if (phase == 1) begin
                if (busy_idx == ack_at || busy_idx == TMO - 1) begin
                    acked = (busy_idx == ack_at);
                    e_err = !acked;
                    if (cur_mem) begin
                        e_mem_ack  = 1;
                        e_mem_data = (acked && !cur_we) ? rd_now : '0;
                    end else begin
                        e_if_ack  = 1;
                        e_if_data = acked ? rd_now : '0;
                    end
                    phase = 2;
                end else begin
                    busy_idx++;
                end
            end else if (phase == 2) begin
                phase = 0;
            end else if (if_pend || mem_pend) begin
                mem_wins = mem_pend && !(if_pend && streak_m == STREAK);
                if (mem_wins) begin
                    cur_mem = 1; cur_a = mem_a; cur_we = mem_w; cur_s = mem_s; cur_d = mem_d;
                    streak_m = if_pend ? ((streak_m + 1 > STREAK) ? STREAK : streak_m + 1) : 0;
                end else begin
                    cur_mem = 0; cur_a = if_a; cur_we = 0; cur_s = 4'hF; cur_d = '0;
                    streak_m = 0;
                end
                phase    = 1;
                busy_idx = 0;
                ack_at   = $urandom_range(0, 9);
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk_quiet("reset");
        chk("reset_stalls", {bus.stall_if_o, bus.stall_mem_o}, 0);

        //           mem we addr          sel    wdata         dly rdata         ewe esel   edout         eerr acyc
        vecs[0] = '{0, 0, 32'h0000_0100, 4'h0, 32'h0,        2,  32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 0, 3};
        vecs[1] = '{1, 1, 32'h0000_0200, 4'h3, 32'h12345678, 0,  32'hAAAA5555, 1, 4'h3, 32'h0,        0, 1};
        vecs[2] = '{1, 0, 32'h0000_0300, 4'hF, 32'h0,        5,  32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D, 0, 6};
        vecs[3] = '{0, 0, 32'h0000_0400, 4'h0, 32'h0,        -1, 32'h11111111, 0, 4'hF, 32'h0,        1, 8};
        vecs[4] = '{1, 0, 32'h0000_0500, 4'hF, 32'h0,        7,  32'h0BADC0DE, 0, 4'hF, 32'h0BADC0DE, 0, 8};
        vecs[5] = '{1, 1, 32'h0000_0600, 4'h8, 32'h55AA55AA, -1, 32'h22222222, 1, 4'h8, 32'h0,        1, 8};
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: MEM first, IF three cycles later.
        do_reset();
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = IF_ADDR;
        bus.mem_req_i  = 1'b1;
        bus.mem_addr_i = 32'h0000_1000;
        bus.mem_sel_i  = 4'hF;
        collect_grants(1'b0, 2);
        chk("simul_order", grant_bits[1:0], 2'b10);
        if (stamps.size() == 2) chk("simul_gap", stamps[1] - stamps[0], 3);

        // MEM hogging while IF waits: four MEM grants, IF, then MEM again.
        do_reset();
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = IF_ADDR;
        bus.mem_req_i  = 1'b1;
        bus.mem_addr_i = 32'h0000_1000;
        bus.mem_sel_i  = 4'hF;
        collect_grants(1'b1, 6);
        chk("streak_order", grant_bits[5:0], 6'b111101);
        for (int i = 0; i + 1 < stamps.size(); i++)
            chk($sformatf("streak_gap%0d", i), stamps[i+1] - stamps[i], 3);

        // Reset while a MEM write is in flight.
        do_reset();
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_addr_i = 32'h0000_0700;
        bus.mem_sel_i  = 4'hF;
        bus.mem_data_i = 32'h7777_7777;
        step();
        chk("rstbusy_ce", bus.ram_ce_o, 1);
        step();
        rst = 1'b1;
        bus.mem_req_i = 1'b0;
        step();
        chk_quiet("rstbusy");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rstbusy_noack%0d", i), {bus.mem_ack_o, bus.err_o, bus.ram_ce_o}, 0);
        end
        run_vec(vecs[2], "post_rst");

        do_reset();
        random_run(3000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
